// File: rtl/insn_buffer_ctrl_pkg.sv
// Shared types for the instruction buffer between fetch and decode.
//   InsnBufferEntry            : one fetched halfword with its pc and fault/interrupt tags
//   insn_buffer_entry_count_t  : occupancy (0..INSN_BUFFER_ENTRY_COUNT)
//   insn_buffer_ptr_t          : head/tail index into the halfword ring
//   is_single_entry()          : true when the halfword forms an instruction by itself
package insn_buffer_ctrl_pkg;

    localparam int unsigned INSN_BUFFER_ENTRY_COUNT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] insn;
        logic        fault;
        logic        interruptValid;
        logic [3:0]  interruptCode;
    } InsnBufferEntry;

    typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT + 1)-1:0] insn_buffer_entry_count_t;
    typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT)-1:0]     insn_buffer_ptr_t;

    // Faulted or interrupt-tagged halfwords are handed over alone so decode
    // sees the event without waiting for a second halfword.
    function automatic logic is_single_entry(input InsnBufferEntry e);
        return e.interruptValid | e.fault | (e.insn[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/insn_buffer_ctrl_if.sv
// Fetch/decode side bundle of the instruction buffer.
//   master : fetch + decode view (drives flush, push data, popReady)
//   slave  : buffer view (drives pushReady, pop data, entryCount)
interface insn_buffer_ctrl_if;
    import insn_buffer_ctrl_pkg::*;

    logic                     flush;
    logic                     pushReady;
    logic [1:0]               pushCount;
    InsnBufferEntry           pushEntry0;
    InsnBufferEntry           pushEntry1;
    logic                     popValid;
    logic                     popReady;
    logic [31:0]              popInsn;
    logic [31:0]              popPc;
    logic                     popCompressed;
    logic                     popFault;
    logic                     popInterruptValid;
    logic [3:0]               popInterruptCode;
    insn_buffer_entry_count_t entryCount;

    modport master (
        output flush, pushCount, pushEntry0, pushEntry1, popReady,
        input  pushReady, popValid, popInsn, popPc, popCompressed, popFault,
               popInterruptValid, popInterruptCode, entryCount
    );

    modport slave (
        input  flush, pushCount, pushEntry0, pushEntry1, popReady,
        output pushReady, popValid, popInsn, popPc, popCompressed, popFault,
               popInterruptValid, popInterruptCode, entryCount
    );

endinterface

// File: rtl/insn_buffer_entry_ram.sv
// Halfword storage for the instruction buffer: ENTRY_COUNT x InsnBufferEntry.
//   clk              : clock
//   we0/waddr0/wdata0: write port 0 (tail)
//   we1/waddr1/wdata1: write port 1 (tail+1)
//   raddr0/rdata0    : async read port 0 (head)
//   raddr1/rdata1    : async read port 1 (head+1)
// Data is not reset; validity is tracked by the controller's count.
module insn_buffer_entry_ram
    import insn_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
) (
    input  logic                           clk,
    input  logic                           we0,
    input  logic [$clog2(ENTRY_COUNT)-1:0] waddr0,
    input  InsnBufferEntry                 wdata0,
    input  logic                           we1,
    input  logic [$clog2(ENTRY_COUNT)-1:0] waddr1,
    input  InsnBufferEntry                 wdata1,
    input  logic [$clog2(ENTRY_COUNT)-1:0] raddr0,
    output InsnBufferEntry                 rdata0,
    input  logic [$clog2(ENTRY_COUNT)-1:0] raddr1,
    output InsnBufferEntry                 rdata1
);

    InsnBufferEntry mem [ENTRY_COUNT];

    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/insn_buffer_ctrl.sv
// Circular halfword instruction buffer controller between fetch and decode.
// Fetch pushes up to two halfwords per cycle; complete 16/32-bit instructions
// are assembled from the head and handed to decode over popValid/popReady.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : insn_buffer_ctrl_if.slave (flush, push side, pop side, entryCount)
// Optional: define RAFI_INSN_BUFFER_BYPASS_EN to let an empty buffer present
// the pushed halfwords to decode in the same cycle (0-cycle latency).
module insn_buffer_ctrl
    import insn_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    insn_buffer_ctrl_if.slave  bus
);

    localparam int unsigned PTR_WIDTH = $clog2(ENTRY_COUNT);
    localparam int unsigned CNT_WIDTH = $clog2(ENTRY_COUNT + 1);

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    ptr_t           head_q, tail_q;
    cnt_t           count_q;

    InsnBufferEntry ram_head, ram_next;
    InsnBufferEntry head_e, next_e;
    logic           push_ready, push_ok, bypass;
    logic           has_one, has_two, single, pop_valid, fire;
    logic [1:0]     push_n, pop_n, store_n, head_adv;
    logic           we0, we1;
    InsnBufferEntry wdata0;

    insn_buffer_entry_ram #(.ENTRY_COUNT(ENTRY_COUNT)) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_q + ptr_t'(1)),
        .wdata1 (bus.pushEntry1),
        .raddr0 (head_q),
        .rdata0 (ram_head),
        .raddr1 (head_q + ptr_t'(1)),
        .rdata1 (ram_next)
    );

    always_comb begin
        push_ready = (count_q <= cnt_t'(ENTRY_COUNT - 2));
        push_ok    = push_ready && ((bus.pushCount == 2'd1) || (bus.pushCount == 2'd2));
        push_n     = push_ok ? bus.pushCount : 2'd0;

        bypass = 1'b0;
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
        bypass = (count_q == '0) && push_ok && !bus.flush;
`endif

        if (bypass) begin
            head_e  = bus.pushEntry0;
            next_e  = bus.pushEntry1;
            has_one = 1'b1;
            has_two = (bus.pushCount == 2'd2);
        end else begin
            head_e  = ram_head;
            next_e  = ram_next;
            has_one = (count_q >= cnt_t'(1));
            has_two = (count_q >= cnt_t'(2));
        end

        single    = is_single_entry(head_e);
        pop_valid = single ? has_one : has_two;
        fire      = pop_valid && bus.popReady;
        pop_n     = fire ? (single ? 2'd1 : 2'd2) : 2'd0;

        // Bypassed halfwords that decode consumes are never stored; the
        // survivors are shifted down to start at tail, and head stays put
        // because it already equals tail in an empty buffer.
        store_n  = push_n;
        head_adv = pop_n;
        wdata0   = bus.pushEntry0;
        if (bypass) begin
            store_n  = push_n - pop_n;
            head_adv = 2'd0;
            if (pop_n == 2'd1) wdata0 = bus.pushEntry1;
        end

        we0 = !bus.flush && (store_n >= 2'd1);
        we1 = !bus.flush && (store_n == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + ptr_t'(head_adv);
            tail_q  <= tail_q + ptr_t'(store_n);
            count_q <= count_q + cnt_t'(store_n) - cnt_t'(head_adv);
        end
    end

    // Pop data is forced to zero while nothing is valid so the port is
    // clean after reset despite the unreset storage.
    always_comb begin
        bus.pushReady         = push_ready;
        bus.entryCount        = insn_buffer_entry_count_t'(count_q);
        bus.popValid          = pop_valid;
        bus.popInsn           = '0;
        bus.popPc             = '0;
        bus.popCompressed     = 1'b0;
        bus.popFault          = 1'b0;
        bus.popInterruptValid = 1'b0;
        bus.popInterruptCode  = '0;
        if (pop_valid) begin
            bus.popPc             = head_e.pc;
            bus.popInterruptValid = head_e.interruptValid;
            bus.popInterruptCode  = head_e.interruptCode;
            if (single) begin
                bus.popInsn       = {16'h0000, head_e.insn};
                bus.popCompressed = (head_e.insn[1:0] != 2'b11);
                bus.popFault      = head_e.fault;
            end else begin
                bus.popInsn       = {next_e.insn, head_e.insn};
                bus.popFault      = next_e.fault;
            end
        end
    end

endmodule

// File: tb/tb_insn_buffer_ctrl.sv
module tb_insn_buffer_ctrl;
    import insn_buffer_ctrl_pkg::*;

    localparam int N = int'(INSN_BUFFER_ENTRY_COUNT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    insn_buffer_ctrl_if bus ();

    insn_buffer_ctrl #(.ENTRY_COUNT(INSN_BUFFER_ENTRY_COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic InsnBufferEntry mk(input logic [31:0] pc, input logic [15:0] insn,
                                          input logic f = 1'b0, input logic iv = 1'b0,
                                          input logic [3:0] code = 4'h0);
        InsnBufferEntry e;
        e.pc = pc;
        e.insn = insn;
        e.fault = f;
        e.interruptValid = iv;
        e.interruptCode = code;
        return e;
    endfunction

    // Reference model: the buffer is a plain queue of halfwords; an
    // instruction is one halfword or two depending on the head.
    InsnBufferEntry mq[$];

    always @(negedge clk) begin : model_chk
        InsnBufferEntry view[$];
        InsnBufferEntry hd;
        int acc;
        int len;
        logic vld;
        logic [31:0] ei;
        if (rst) begin
            mq.delete();
        end else begin
            acc = (((bus.pushCount == 2'd1) || (bus.pushCount == 2'd2)) && (N - mq.size() >= 2))
                  ? int'(bus.pushCount) : 0;
            view = mq;
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
            if (mq.size() == 0 && acc > 0 && !bus.flush) begin
                view.push_back(bus.pushEntry0);
                if (acc == 2) view.push_back(bus.pushEntry1);
            end
`endif
            check("m_pushReady", 64'(bus.pushReady), 64'(N - mq.size() >= 2));
            check("m_entryCount", 64'(bus.entryCount), 64'(mq.size()));
            vld = 1'b0;
            len = 0;
            if (view.size() > 0) begin
                hd  = view[0];
                len = (hd.interruptValid || hd.fault || hd.insn[1:0] != 2'b11) ? 1 : 2;
                vld = (view.size() >= len);
            end
            check("m_popValid", 64'(bus.popValid), 64'(vld));
            if (vld) begin
                ei = (len == 1) ? {16'h0000, hd.insn} : {view[1].insn, hd.insn};
                check("m_popInsn", 64'(bus.popInsn), 64'(ei));
                check("m_popPc", 64'(bus.popPc), 64'(hd.pc));
                check("m_popCompressed", 64'(bus.popCompressed),
                      64'((len == 1) && (hd.insn[1:0] != 2'b11)));
                check("m_popFault", 64'(bus.popFault), 64'((len == 1) ? hd.fault : view[1].fault));
                check("m_popIntValid", 64'(bus.popInterruptValid), 64'(hd.interruptValid));
                check("m_popIntCode", 64'(bus.popInterruptCode), 64'(hd.interruptCode));
            end
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (acc >= 1) mq.push_back(bus.pushEntry0);
                if (acc == 2) mq.push_back(bus.pushEntry1);
                if (vld && bus.popReady) begin
                    for (int k = 0; k < len; k++) void'(mq.pop_front());
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; checks happen on the
    // following falling edge.
    task automatic drive(input logic fl, input logic [1:0] cnt, input InsnBufferEntry e0,
                         input InsnBufferEntry e1, input logic rdy);
        @(posedge clk);
        #1;
        bus.flush      = fl;
        bus.pushCount  = cnt;
        bus.pushEntry0 = e0;
        bus.pushEntry1 = e1;
        bus.popReady   = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 2'd0, '0, '0, rdy);
    endtask

    InsnBufferEntry cn;
    InsnBufferEntry a0, a1;

    initial begin
        bus.flush      = 1'b0;
        bus.pushCount  = 2'd0;
        bus.pushEntry0 = '0;
        bus.pushEntry1 = '0;
        bus.popReady   = 1'b0;
        cn = mk(32'h8000_1000, 16'h0001);

        // reset values
        @(negedge clk);
        check("rst_popValid", 64'(bus.popValid), 64'd0);
        check("rst_pushReady", 64'(bus.pushReady), 64'd1);
        check("rst_entryCount", 64'(bus.entryCount), 64'd0);
        check("rst_popInsn", 64'(bus.popInsn), 64'd0);
        check("rst_popPc", 64'(bus.popPc), 64'd0);
        check("rst_popCompressed", 64'(bus.popCompressed), 64'd0);
        check("rst_popFault", 64'(bus.popFault), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // two compressed instructions
        drive(1'b0, 2'd2, mk(32'h8000_0000, 16'h4501), mk(32'h8000_0002, 16'h4581), 1'b0);
        idle(1'b0);
        check("c1_popValid", 64'(bus.popValid), 64'd1);
        check("c1_popInsn", 64'(bus.popInsn), 64'h0000_4501);
        check("c1_popCompressed", 64'(bus.popCompressed), 64'd1);
        check("c1_popPc", 64'(bus.popPc), 64'h8000_0000);
        idle(1'b1);
        idle(1'b1);
        check("c2_popInsn", 64'(bus.popInsn), 64'h0000_4581);
        check("c2_popPc", 64'(bus.popPc), 64'h8000_0002);
        idle(1'b0);
        check("c2_empty", 64'(bus.entryCount), 64'd0);

        // 32-bit instruction held then popped
        drive(1'b0, 2'd2, mk(32'h8000_0010, 16'h0093), mk(32'h8000_0012, 16'h0010), 1'b0);
        idle(1'b0);
        check("w_popInsn", 64'(bus.popInsn), 64'h0010_0093);
        check("w_popCompressed", 64'(bus.popCompressed), 64'd0);
        check("w_entryCount", 64'(bus.entryCount), 64'd2);
        idle(1'b1);
        idle(1'b0);
        check("w_drained", 64'(bus.entryCount), 64'd0);

        // fill to full, drop an extra push
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        check("full_pushReady", 64'(bus.pushReady), 64'd0);
        check("full_entryCount", 64'(bus.entryCount), 64'd4);
        idle(1'b0);
        check("full_dropped", 64'(bus.entryCount), 64'd4);
        check("full_popValid", 64'(bus.popValid), 64'd1);
        repeat (4) idle(1'b1);

        // straddle index 3 -> 0
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        drive(1'b0, 2'd1, cn, cn, 1'b0);
        repeat (3) idle(1'b1);
        drive(1'b0, 2'd2, mk(32'h8000_0020, 16'h0093), mk(32'h8000_0022, 16'h0010), 1'b0);
        idle(1'b0);
        check("wrap_popInsn", 64'(bus.popInsn), 64'h0010_0093);
        check("wrap_entryCount", 64'(bus.entryCount), 64'd2);
        idle(1'b1);

        // fault on upper half
        drive(1'b0, 2'd2, mk(32'h8000_0100, 16'h0093), mk(32'h8000_0102, 16'h0010, 1'b1), 1'b0);
        idle(1'b0);
        check("flt_popFault", 64'(bus.popFault), 64'd1);
        check("flt_popPc", 64'(bus.popPc), 64'h8000_0100);
        idle(1'b1);
        idle(1'b0);
        check("flt_consumed2", 64'(bus.entryCount), 64'd0);

        // interrupt on head
        drive(1'b0, 2'd2, mk(32'h8000_0200, 16'h0093, 1'b0, 1'b1, 4'd7),
              mk(32'h8000_0202, 16'h0010), 1'b0);
        idle(1'b0);
        check("irq_valid", 64'(bus.popInterruptValid), 64'd1);
        check("irq_code", 64'(bus.popInterruptCode), 64'd7);
        check("irq_popInsn", 64'(bus.popInsn), 64'h0000_0093);
        idle(1'b1);
        idle(1'b0);
        check("irq_consumed1", 64'(bus.entryCount), 64'd1);
        idle(1'b1);

        // flush with concurrent push
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        drive(1'b0, 2'd1, cn, cn, 1'b0);
        drive(1'b1, 2'd2, cn, cn, 1'b1);
        check("fl_before", 64'(bus.entryCount), 64'd3);
        idle(1'b0);
        check("fl_entryCount", 64'(bus.entryCount), 64'd0);
        check("fl_popValid", 64'(bus.popValid), 64'd0);
        check("fl_pushReady", 64'(bus.pushReady), 64'd1);

        // push-to-pop latency
        drive(1'b0, 2'd1, mk(32'h8000_0300, 16'h4501), '0, 1'b0);
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
        check("lat_popValid", 64'(bus.popValid), 64'd1);
        check("lat_popInsn", 64'(bus.popInsn), 64'h0000_4501);
`else
        check("lat_popValid", 64'(bus.popValid), 64'd0);
`endif
        idle(1'b1);
        drive(1'b0, 2'd2, mk(32'h8000_0310, 16'h4501), mk(32'h8000_0312, 16'h4581), 1'b1);
        idle(1'b0);
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
        check("lat_remaining", 64'(bus.entryCount), 64'd1);
`else
        check("lat_remaining", 64'(bus.entryCount), 64'd2);
`endif
        check("lat_headPc", 64'(bus.popPc),
`ifdef RAFI_INSN_BUFFER_BYPASS_EN
              64'h8000_0312);
`else
              64'h8000_0310);
`endif
        repeat (2) idle(1'b1);
        drive(1'b0, 2'd2, mk(32'h8000_0320, 16'h0093), mk(32'h8000_0322, 16'h0010), 1'b1);
        idle(1'b1);

        // mixed simultaneous push/pop traffic
        for (int i = 0; i < 28; i++) begin
            a0 = mk(32'h8000_0400 + 32'(4 * i), (i % 2 == 0) ? 16'h0093 : 16'(16'h4501 + i),
                    (i % 7 == 3), (i % 9 == 5), 4'(i));
            a1 = mk(32'h8000_0402 + 32'(4 * i), 16'(16'h0010 + 16'(i << 2)), (i % 5 == 4));
            drive(i == 17, 2'(i % 3), a0, a1, (i % 4) != 3);
        end
        repeat (4) idle(1'b1);

        // asynchronous reset mid-operation
        drive(1'b0, 2'd2, cn, cn, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_popValid", 64'(bus.popValid), 64'd0);
        check("arst_entryCount", 64'(bus.entryCount), 64'd0);
        check("arst_pushReady", 64'(bus.pushReady), 64'd1);
        check("arst_popInsn", 64'(bus.popInsn), 64'd0);
        bus.pushCount = 2'd0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 2'd2, mk(32'h8000_0500, 16'h4501), mk(32'h8000_0502, 16'h4581), 1'b0);
        idle(1'b0);
        check("arst_reuse_popInsn", 64'(bus.popInsn), 64'h0000_4501);
        check("arst_reuse_entryCount", 64'(bus.entryCount), 64'd2);
        repeat (3) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
